ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Receives the PS/2 keyboard serial stream and converts it into the single-cycle key pulses that the game controller consumes: up, down, left, right and start_key.
- Sits between the board PS2_CLK/PS2_DAT pins and the control block in game2048.
- It is the producing end of the control block's direction/start inputs.
- Handles PS/2 frame reception, scan-code prefix decoding (E0 extended, F0 break) and auto-repeat suppression.

Parameters:
- TIMEOUT_CYCLES, 100000, clocks without a PS/2 falling edge before a partial frame is abandoned (2 ms at 50 MHz).
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers on ps2_clk/ps2_dat; legal values 2 or 3.

Ports:
- clock  input  1  system clock (CLOCK_50 at top level); all state on rising edge.
- start  input  1  reset, asynchronous, active-high; clears all state.
- ps2_clk  input  1  raw keyboard clock, asynchronous to clock.
- ps2_dat  input  1  raw keyboard data, asynchronous to clock.
- up  output  1  one-cycle pulse on make of Up arrow (E0 75).
- down  output  1  one-cycle pulse on make of Down arrow (E0 72).
- left  output  1  one-cycle pulse on make of Left arrow (E0 6B).
- right  output  1  one-cycle pulse on make of Right arrow (E0 74).
- start_key  output  1  one-cycle pulse on make of S (1B, non-extended).
- rx_byte  output  8  last correctly received byte, held until the next one.
- rx_valid  output  1  one-cycle pulse when rx_byte updates.
- frame_err  output  1  one-cycle pulse on parity/stop/timeout error.

Behaviour:
- Reset values:
  - All outputs are 0, rx_byte = 8'h00.
  - Frame FSM = IDLE; ext and brk flags = 0; held[4:0] = 0; timeout counter = 0.
- Synchronisation and edge detection:
  - ps2_clk and ps2_dat pass through SYNC_STAGES flip-flops.
  - A falling edge is the synchronised clock going 1 to 0 between consecutive cycles.
  - Data is sampled in the same cycle the edge is detected.
- Frame FSM (11-bit frame: start 0, D0..D7 LSB first, odd parity, stop 1):
  - IDLE: on an edge with data 0, go to DATA with bitcnt = 0. On an edge with data 1, stay in IDLE with no error.
  - DATA: each edge shifts data into shreg[7] (right shift) and increments bitcnt. After the 8th bit, go to PARITY.
  - PARITY: each edge stores the parity bit and moves to STOP.
  - STOP: on an edge, if stop = 1 and XOR(shreg, parity) = 1, the byte is good: rx_byte <= shreg and rx_valid pulses next cycle. Otherwise frame_err pulses and the byte is discarded. Both cases return to IDLE.
  - Timeout: in any state other than IDLE, the counter increments each clock and resets on every edge. When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE and frame_err pulses. The counter is held at 0 in IDLE.
- Scan decoder (acts on each good byte, same cycle as rx_valid):
  - E0: set ext. F0: set brk. Prefixes may arrive in either order; no output is produced.
  - Any other byte is looked up using the current ext/brk, then both flags are cleared.
  - Key index mapping (used for held[]): ext & 75 = up (0), ext & 72 = down (1), ext & 6B = left (2), ext & 74 = right (3), !ext & 1B = start_key (4).
  - Make (brk = 0): pulse the matching output only if held[k] = 0, then set held[k]. Typematic repeats therefore produce no further pulses.
  - Break (brk = 1): clear held[k]; no pulse.
  - Unmapped code, or 1B with ext set: clear flags, no output.
  - A frame error clears ext and brk; held[] is untouched.
- Latency: a key pulse, rx_valid and frame_err all assert exactly 1 cycle after the cycle in which the stop-bit edge is detected. At most one direction pulse is asserted per cycle.
- Reset mid-frame: asynchronous clear. The next frame is received normally only if its start bit follows the deassertion of reset.
- Pins are input only; host-to-device transmission is out of scope.

Decomposition:
- Package ps2_pkg holds:
  - Scan-code constants: SC_EXT = 8'hE0, SC_BRK = 8'hF0, SC_UP = 8'h75, SC_DOWN = 8'h72, SC_LEFT = 8'h6B, SC_RIGHT = 8'h74, SC_S = 8'h1B.
  - Key index constants 0..4.
  - Frame FSM state encoding.
- One natural sub-module, ps2_rx_frame: synchroniser, edge detect, frame FSM and timeout. It outputs byte, valid and err.
- The top of this block holds the prefix flags, held mask and pulse logic.

Test Plan:
- Frame E0, then 75 (valid odd parity) -> rx_valid pulses twice, rx_byte = 75, up pulses exactly once, 1 cycle after the second stop edge; all other key outputs stay 0.
- S held with typematic repeat: 1B, 1B, 1B, then F0, then 1B -> start_key pulses once and held[4] = 0 at the end. A following 1B pulses start_key again.
- Frame 6B with parity bit inverted -> frame_err pulses, rx_byte remains the previous value, no left pulse. A subsequent E0 6B -> left pulses.
- 4 data bits sent, then the clock idles for 100000 cycles -> frame_err pulses on cycle 100000 and the FSM is back in IDLE. A full E0 74 afterwards -> right pulses.
- Reset asserted during bit D3 of a frame, released, then E0 72 sent -> no output during or after the aborted frame; down pulses once for the new frame.
- Codes 1C, then E0 1B, then F0 75 with nothing held -> no key pulses and no frame_err. rx_valid pulses for each byte; prefix flags are clear afterwards.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_pkg                                                              |
// | Scan codes, key indices and frame-FSM encoding for ps2_key_decoder.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ps2_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_S     = 8'h1B;

   localparam int KEY_UP    = 0;
   localparam int KEY_DOWN  = 1;
   localparam int KEY_LEFT  = 2;
   localparam int KEY_RIGHT = 3;
   localparam int KEY_START = 4;
   localparam int KEY_N     = 5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } frame_state_t;

   // One-hot key index for a non-prefix code; zero when the code is unmapped.
   function automatic logic [KEY_N-1:0] key_hit(input logic [7:0] code, input logic ext);
      logic [KEY_N-1:0] hit;
      hit = '0;
      if (ext) begin
         case (code)
            SC_UP:    hit[KEY_UP]    = 1'b1;
            SC_DOWN:  hit[KEY_DOWN]  = 1'b1;
            SC_LEFT:  hit[KEY_LEFT]  = 1'b1;
            SC_RIGHT: hit[KEY_RIGHT] = 1'b1;
            default:  hit = '0;
         endcase
      end else if (code == SC_S) begin
         hit[KEY_START] = 1'b1;
      end
      return hit;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_rx_frame                                                         |
// | PS/2 pin synchroniser, falling-edge detect, 11-bit frame FSM, timeout|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_dat,
   output logic [7:0] o_byte,
   output logic       o_valid,
   output logic       o_err
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
   logic                   clk_prev_q, clk_prev_d;
   frame_state_t           state_q, state_d;
   logic [2:0]             bitcnt_q, bitcnt_d;
   logic [7:0]             shreg_q, shreg_d;
   logic                   parity_q, parity_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [7:0]             byte_q, byte_d;
   logic                   valid_q, valid_d;
   logic                   err_q, err_d;

   logic w_clk_s;
   logic w_dat_s;
   logic w_fall;

   assign w_clk_s = clk_sync_q[SYNC_STAGES-1];
   assign w_dat_s = dat_sync_q[SYNC_STAGES-1];
   assign w_fall  = clk_prev_q & ~w_clk_s;

   always_comb begin
      clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], i_ps2_clk};
      dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], i_ps2_dat};
      clk_prev_d = w_clk_s;
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      shreg_d    = shreg_q;
      parity_d   = parity_q;
      cnt_d      = cnt_q;
      byte_d     = byte_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;

      if (state_q == ST_IDLE || w_fall) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (w_fall && !w_dat_s) begin
               state_d  = ST_DATA;
               bitcnt_d = 3'd0;
            end
         end
         ST_DATA: begin
            if (w_fall) begin
               shreg_d  = {w_dat_s, shreg_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  state_d = ST_PARITY;
               end
            end
         end
         ST_PARITY: begin
            if (w_fall) begin
               parity_d = w_dat_s;
               state_d  = ST_STOP;
            end
         end
         ST_STOP: begin
            if (w_fall) begin
               // Odd parity: data bits plus parity bit must XOR to one.
               if (w_dat_s && ((^shreg_q) ^ parity_q)) begin
                  byte_d  = shreg_q;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_q != ST_IDLE && !w_fall && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync_q <= '0;
         dat_sync_q <= '0;
         clk_prev_q <= 1'b0;
         state_q    <= ST_IDLE;
         bitcnt_q   <= 3'd0;
         shreg_q    <= 8'h00;
         parity_q   <= 1'b0;
         cnt_q      <= '0;
         byte_q     <= 8'h00;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         clk_sync_q <= clk_sync_d;
         dat_sync_q <= dat_sync_d;
         clk_prev_q <= clk_prev_d;
         state_q    <= state_d;
         bitcnt_q   <= bitcnt_d;
         shreg_q    <= shreg_d;
         parity_q   <= parity_d;
         cnt_q      <= cnt_d;
         byte_q     <= byte_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

   assign o_byte  = byte_q;
   assign o_valid = valid_q;
   assign o_err   = err_q;

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_key_decoder                                                      |
// | PS/2 keyboard to one-cycle direction/start pulses for game control.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clock,
   input  logic       start,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic       up,
   output logic       down,
   output logic       left,
   output logic       right,
   output logic       start_key,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       frame_err
);

   logic [7:0] w_rx_byte;
   logic       w_rx_valid;
   logic       w_rx_err;

   ps2_rx_frame #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) u_rx_frame (
      .clk       (clock),
      .rst       (start),
      .i_ps2_clk (ps2_clk),
      .i_ps2_dat (ps2_dat),
      .o_byte    (w_rx_byte),
      .o_valid   (w_rx_valid),
      .o_err     (w_rx_err)
   );

   logic             ext_q, ext_d;
   logic             brk_q, brk_d;
   logic [KEY_N-1:0] held_q, held_d;
   logic [KEY_N-1:0] w_hit;
   logic [KEY_N-1:0] w_pulse;

   assign w_hit = key_hit(w_rx_byte, ext_q);

   // Pulses come straight from registered byte/flags so they line up with rx_valid.
   always_comb begin
      ext_d   = ext_q;
      brk_d   = brk_q;
      held_d  = held_q;
      w_pulse = '0;
      if (w_rx_err) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (w_rx_valid) begin
         if (w_rx_byte == SC_EXT) begin
            ext_d = 1'b1;
         end else if (w_rx_byte == SC_BRK) begin
            brk_d = 1'b1;
         end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (brk_q) begin
               held_d = held_q & ~w_hit;
            end else begin
               w_pulse = w_hit & ~held_q;
               held_d  = held_q | w_hit;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge start) begin
      if (start) begin
         ext_q  <= 1'b0;
         brk_q  <= 1'b0;
         held_q <= '0;
      end else begin
         ext_q  <= ext_d;
         brk_q  <= brk_d;
         held_q <= held_d;
      end
   end

   assign up        = w_pulse[KEY_UP];
   assign down      = w_pulse[KEY_DOWN];
   assign left      = w_pulse[KEY_LEFT];
   assign right     = w_pulse[KEY_RIGHT];
   assign start_key = w_pulse[KEY_START];
   assign rx_byte   = w_rx_byte;
   assign rx_valid  = w_rx_valid;
   assign frame_err = w_rx_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ps2_key_decoder                                                   |
// | Scoreboard bench: directed PS/2 frames, monitor compares outputs.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ps2_key_decoder;

   localparam int TIMEOUT = 2000;
   localparam int SYNC    = 2;
   localparam int HALF    = 20;
   localparam int LAT     = SYNC + 1;

   typedef struct packed {
      logic       valid;
      logic       err;
      logic [7:0] data;
      logic [4:0] keys;
      logic       chk_lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       start = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic       up, down, left, right, start_key;
   logic [7:0] rx_byte;
   logic       rx_valid, frame_err;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   last_edge_cyc = 0;
   int   err_cyc = 0;

   ps2_key_decoder #(
      .TIMEOUT_CYCLES (TIMEOUT),
      .SYNC_STAGES    (SYNC)
   ) dut (
      .clock     (clk),
      .start     (start),
      .ps2_clk   (ps2_clk),
      .ps2_dat   (ps2_dat),
      .up        (up),
      .down      (down),
      .left      (left),
      .right     (right),
      .start_key (start_key),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every cycle with any output active consumes one expectation.
   always @(negedge clk) begin
      exp_t e;
      logic [14:0] obs;
      if (!start && (rx_valid || frame_err || up || down || left || right || start_key)) begin
         obs = {rx_valid, frame_err, rx_byte, start_key, right, left, down, up};
         if (frame_err) err_cyc = cyc;
         n_cmp++;
         if (sbq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output: got v/e/byte/keys=%h, wanted no output", obs);
         end else begin
            e = sbq.pop_front();
            if (obs != {e.valid, e.err, e.data, e.keys}) begin
               n_bad++;
               $display("FAIL event: got v/e/byte/keys=%h, wanted %h", obs,
                        {e.valid, e.err, e.data, e.keys});
            end
            if (e.chk_lat) begin
               n_cmp++;
               if (cyc != last_edge_cyc + LAT) begin
                  n_bad++;
                  $display("FAIL latency: got %0d cycles after stop edge, wanted %0d",
                           cyc - last_edge_cyc, LAT);
               end
            end
         end
      end
   end

   task automatic ps2_bit(input logic b);
      @(negedge clk);
      ps2_dat = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      last_edge_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(~(^b) ^ bad_par);
      ps2_bit(1'b1);
      repeat (HALF) @(negedge clk);
   endtask

   task automatic expect_ev(input logic v, input logic e, input logic [7:0] rb,
                            input logic [4:0] k, input logic lat);
      exp_t x;
      x.valid = v; x.err = e; x.data = rb; x.keys = k; x.chk_lat = lat;
      sbq.push_back(x);
   endtask

   // Good frame: rx_valid with this byte and the given key pulses {s,r,l,d,u}.
   task automatic good(input logic [7:0] b, input logic [4:0] k);
      expect_ev(1'b1, 1'b0, b, k, 1'b1);
      send_frame(b, 1'b0);
   endtask

   task automatic check(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0h, wanted %0h", name, got, want);
      end
   endtask

   initial begin
      repeat (5) @(negedge clk);
      check("reset_rx_byte", int'(rx_byte), 0);
      check("reset_outputs", int'({up, down, left, right, start_key, rx_valid, frame_err}), 0);
      start = 1'b0;
      repeat (10) @(negedge clk);

      // Up arrow make.
      good(8'hE0, 5'b00000);
      good(8'h75, 5'b00001);

      // S typematic repeat, release, press again, release; then release Up (F0 before E0).
      good(8'h1B, 5'b10000);
      good(8'h1B, 5'b00000);
      good(8'h1B, 5'b00000);
      good(8'hF0, 5'b00000);
      good(8'h1B, 5'b00000);
      good(8'h1B, 5'b10000);
      good(8'hF0, 5'b00000);
      good(8'h1B, 5'b00000);
      good(8'hF0, 5'b00000);
      good(8'hE0, 5'b00000);
      good(8'h75, 5'b00000);

      // Bad parity after E0: error, rx_byte kept, ext cleared so 1B is a plain S.
      good(8'hE0, 5'b00000);
      expect_ev(1'b0, 1'b1, 8'hE0, 5'b00000, 1'b1);
      send_frame(8'h6B, 1'b1);
      good(8'h1B, 5'b10000);
      good(8'hF0, 5'b00000);
      good(8'h1B, 5'b00000);
      good(8'hE0, 5'b00000);
      good(8'h6B, 5'b00100);
      good(8'hE0, 5'b00000);
      good(8'hF0, 5'b00000);
      good(8'h6B, 5'b00000);

      // Partial frame then silence: timeout error.
      expect_ev(1'b0, 1'b1, 8'h6B, 5'b00000, 1'b0);
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(i[0]);
      repeat (TIMEOUT + 40) @(negedge clk);
      check("timeout_cycle", err_cyc - last_edge_cyc, TIMEOUT + SYNC + 1);
      good(8'hE0, 5'b00000);
      good(8'h74, 5'b01000);
      good(8'hF0, 5'b00000);
      good(8'hE0, 5'b00000);
      good(8'h74, 5'b00000);

      // Reset during D3 of an aborted frame.
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(i[1]);
      @(negedge clk);
      start = 1'b1;
      repeat (3) @(negedge clk);
      check("midreset_outputs", int'({up, down, left, right, start_key, rx_valid, frame_err}), 0);
      start = 1'b0;
      @(negedge clk);
      check("midreset_rx_byte", int'(rx_byte), 0);
      repeat (TIMEOUT + 50) @(negedge clk);
      good(8'hE0, 5'b00000);
      good(8'h72, 5'b00010);
      good(8'hE0, 5'b00000);
      good(8'hF0, 5'b00000);
      good(8'h72, 5'b00000);

      // Unmapped, extended S, break of unheld key; flags must be clear afterwards.
      good(8'h1C, 5'b00000);
      good(8'hE0, 5'b00000);
      good(8'h1B, 5'b00000);
      good(8'hF0, 5'b00000);
      good(8'h75, 5'b00000);
      good(8'h1B, 5'b10000);

      repeat (50) @(negedge clk);
      check("scoreboard_drained", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
